ad_capture_buf: RTL and testbench

Triggered ADC capture buffer on the AD/DA signal path; the write-side counterpart of the waveform ROMs the DA generators read from. It watches an 8-bit ADC sample stream and, once armed, waits for a rising crossing of a trigger level. It then writes a full frame into an internal single-port RAM and streams the frame out through a valid/ready interface to the processing/display logic.

---
 rtl/ad_capture_buf.sv | 163 ++++++++++++++++
 tb/tb_ad_capture_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad_capture_buf.sv
// Triggered ADC capture buffer: arms, waits for a rising crossing of TRIG_LEVEL,
// records one DEPTH-sample frame into a single-port RAM and streams it out over valid/ready.
module ad_capture_buf #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int TRIG_LEVEL = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ad_data,
    input  logic                  ad_valid,
    input  logic                  arm,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] TRIG = DATA_WIDTH'(TRIG_LEVEL);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0]   prev_reg;
    logic                    prev_ok_reg;
    logic                    done_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic                    mem_re;

    // Readout pipeline: RAM output stage (q_*) feeding the output register (rd_*).
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic                    fetch_done_reg;
    logic                    q_valid_reg;
    logic                    q_last_reg;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    rd_valid_reg;
    logic                    rd_last_reg;

    logic                    advance;
    logic                    last_hs;
    logic                    readout_go;
    logic [DATA_WIDTH:0]     prev_diff;
    logic [DATA_WIDTH:0]     cur_diff;
    logic                    crossing;

    // Unsigned compares via the borrow bit, so a zero level simply never crosses.
    assign prev_diff = {1'b0, prev_reg} - {1'b0, TRIG};
    assign cur_diff  = {1'b0, ad_data} - {1'b0, TRIG};
    assign crossing  = prev_ok_reg && prev_diff[DATA_WIDTH] && !cur_diff[DATA_WIDTH];

    assign advance    = !rd_valid_reg || rd_ready;
    assign last_hs    = rd_valid_reg && rd_ready && rd_last_reg;
    assign readout_go = (state_reg == READOUT) && !abort;
    assign mem_re     = readout_go && advance && !fetch_done_reg;
    assign mem_addr   = (state_reg == READOUT) ? rd_addr_reg : wr_addr_reg;

    always_comb begin
        state_next   = state_reg;
        wr_addr_next = wr_addr_reg;
        mem_we       = 1'b0;
        case (state_reg)
            IDLE: begin
                wr_addr_next = '0;
                if (arm) state_next = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (ad_valid && crossing) begin
                    mem_we       = 1'b1;
                    wr_addr_next = ADDR_WIDTH'(1);
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (ad_valid) begin
                    mem_we       = 1'b1;
                    wr_addr_next = wr_addr_reg + 1'b1;
                    if (wr_addr_reg == LAST_ADDR) state_next = READOUT;
                end
            end
            READOUT: begin
                if (last_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next   = IDLE;
            wr_addr_next = '0;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wr_addr_reg <= '0;
            prev_reg    <= '0;
            prev_ok_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_addr_reg <= wr_addr_next;
            done_reg    <= readout_go && last_hs;
            if (state_reg == IDLE) begin
                prev_ok_reg <= 1'b0;
            end else if (state_reg == WAIT_TRIG && ad_valid) begin
                prev_reg    <= ad_data;
                prev_ok_reg <= 1'b1;
            end
        end
    end

    // Single-port RAM; the read register only updates when the pipeline advances.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= ad_data;
        if (mem_re) mem_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg    <= '0;
            fetch_done_reg <= 1'b0;
            q_valid_reg    <= 1'b0;
            q_last_reg     <= 1'b0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
        end else if (!readout_go) begin
            rd_addr_reg    <= '0;
            fetch_done_reg <= 1'b0;
            q_valid_reg    <= 1'b0;
            q_last_reg     <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
        end else if (advance) begin
            rd_valid_reg <= q_valid_reg;
            rd_last_reg  <= q_valid_reg && q_last_reg;
            if (q_valid_reg) rd_data_reg <= mem_q;
            q_valid_reg <= !fetch_done_reg;
            q_last_reg  <= (rd_addr_reg == LAST_ADDR);
            if (!fetch_done_reg) begin
                if (rd_addr_reg == LAST_ADDR) fetch_done_reg <= 1'b1;
                else                          rd_addr_reg    <= rd_addr_reg + 1'b1;
            end
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_last  = rd_last_reg;

endmodule

// File: tb/tb_ad_capture_buf.sv
// Bench for ad_capture_buf: random/directed sample streams against a frame model
// built from the fed sample list; a second instance with a zero trigger level.
module tb_ad_capture_buf;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int LVL   = 128;

    logic clk = 1'b0;
    logic rst, rst0, ad_valid, arm, abort, rd_ready, arm0, abort0;
    logic [DW-1:0] ad_data;
    logic busy, done, rd_valid, rd_last;
    logic [DW-1:0] rd_data;
    logic busy0, done0, rd_valid0, rd_last0;
    logic [DW-1:0] rd_data0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rv0_seen = 1'b0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } samp_t;
    samp_t fed[$];

    always #5 clk = ~clk;

    ad_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRIG_LEVEL(LVL)) dut (
        .clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid),
        .arm(arm), .abort(abort), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
    );

    ad_capture_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRIG_LEVEL(0)) dut0 (
        .clk(clk), .rst(rst0), .ad_data(ad_data), .ad_valid(ad_valid),
        .arm(arm0), .abort(abort0), .busy(busy0), .done(done0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_last(rd_last0)
    );

    always @(posedge clk) if (rd_valid0 === 1'b1) rv0_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] gen(input int dmode, input int k);
        logic [7:0] pre [7];
        pre = '{8'd200, 8'd150, 8'd100, 8'd50, 8'd90, 8'd127, 8'd128};
        if (dmode == 0) return k[7:0];
        if (dmode == 1 && k < 7) return pre[k];
        return 8'($urandom);
    endfunction

    // dmode: 0 ramp, 1 directed prefix then random, 2 random
    // vmode: 0 strobe every cycle, 1 every 3rd cycle; rmode: 0 ready high, 1 random ready
    task automatic run_frame(input int dmode, input int vmode, input int rmode,
                             input bit arm_cap, input bit arm_ro, input int abort_at);
        int n, k, t, idx, m, vcount;
        logic [7:0] d, pd;
        logic pl, stalled, v;
        logic [7:0] exp_q[$];

        fed.delete();
        exp_q.delete();
        k = 0;
        n = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);

        while (rd_valid !== 1'b1 && n < 20000) begin
            v = (vmode == 0) || (n % 3 == 2);
            d = 8'($urandom);
            if (v) begin
                d = gen(dmode, k);
                k++;
                fed.push_back('{d, cyc + 1});
            end
            ad_valid = v;
            ad_data  = d;
            arm      = arm_cap && (n == 400);
            step();
            n++;
        end
        ad_valid = 1'b0;
        arm      = 1'b0;
        if (rd_valid !== 1'b1) begin
            chk("rd_valid_timeout", rd_valid, 1);
            return;
        end

        t = -1;
        for (int i = 1; i < fed.size(); i++) begin
            if (fed[i-1].d < LVL && fed[i].d >= LVL) begin
                t = i;
                break;
            end
        end
        if (t < 0 || t + DEPTH > fed.size()) begin
            chk("model_no_frame", 0, 1);
            return;
        end
        if (dmode == 0) chk("trig_index_ramp", t, 128);
        if (dmode == 1) chk("trig_index_directed", t, 6);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(fed[t+i].d);
        chk("first_valid_latency", cyc, fed[t+DEPTH-1].c + 2);

        idx = 0;
        m = 0;
        vcount = 0;
        while (idx < DEPTH && m < 20000) begin
            rd_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            arm      = arm_ro && (idx == 500);
            if (idx == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_rd_valid", rd_valid, 0);
                chk("abort_rd_last", rd_last, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                step();
                chk("abort_done_later", done, 0);
                return;
            end
            if (rd_valid === 1'b1) vcount++;
            if (rd_valid === 1'b1 && rd_ready) begin
                chk($sformatf("rd_data[%0d]", idx), rd_data, exp_q[idx]);
                chk($sformatf("rd_last[%0d]", idx), rd_last, (idx == DEPTH - 1));
                idx++;
            end
            stalled = (rd_valid === 1'b1) && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            step();
            m++;
            if (stalled) begin
                chk("stall_valid", rd_valid, 1);
                chk("stall_data", rd_data, pd);
                chk("stall_last", rd_last, pl);
            end
        end
        arm = 1'b0;
        chk("readout_count", idx, DEPTH);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("rd_valid_at_done", rd_valid, 0);
        if (rmode == 0) chk("consecutive_valid", vcount, DEPTH);
        rd_ready = 1'b0;
        step();
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; rst0 = 1'b1;
        ad_valid = 1'b0; ad_data = '0; arm = 1'b0; abort = 1'b0;
        rd_ready = 1'b0; arm0 = 1'b0; abort0 = 1'b0;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_last", rd_last, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 1'b0; rst0 = 1'b0;
        step();

        arm0 = 1'b1;
        step();
        arm0 = 1'b0;
        chk("lvl0_busy_armed", busy0, 1);

        run_frame(0, 0, 0, 1'b1, 1'b1, -1);
        run_frame(1, 0, 1, 1'b0, 1'b0, -1);
        run_frame(2, 1, 1, 1'b0, 1'b0, -1);
        run_frame(2, 0, 1, 1'b0, 1'b0, 300);
        run_frame(2, 0, 0, 1'b0, 1'b0, -1);

        // Reset in the middle of a capture.
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ad_valid = 1'b1;
            ad_data  = i[7:0];
            step();
        end
        chk("capture_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ad_valid = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        step();
        chk("rst_busy_hold", busy, 0);

        run_frame(2, 1, 1, 1'b0, 1'b0, -1);

        chk("lvl0_busy_stuck", busy0, 1);
        chk("lvl0_never_valid", rv0_seen, 0);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("lvl0_abort_busy", busy0, 0);
        chk("lvl0_abort_done", done0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
